// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin arbiter over 4 requesters feeding a single
// clk_a-to-clk_b synchronizer. Each transfer holds xfer_en/xfer_data for
// HOLD_CYC cycles, then keeps xfer_data stable for GAP_CYC idle cycles.
// Optional macro CDC_XFER_ACK_EN adds a clk_b-domain level acknowledge
// (ack_b) that additionally gates the end of HOLD (ack high) and GAP (ack low).
module cdc_xfer_arbiter #(
   parameter int HOLD_CYC = 6,
   parameter int GAP_CYC  = 2
) (
   input  logic        clk_a,
   input  logic        arst,
`ifdef CDC_XFER_ACK_EN
   input  logic        ack_b,
`endif
   input  logic [3:0]  req,
   input  logic [15:0] req_data,
   output logic [3:0]  xfer_data,
   output logic        xfer_en,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [1:0] r_last, w_last_nxt;
   logic [3:0] r_data, w_data_nxt;
   logic [3:0] r_gnt, w_gnt_nxt;
   logic [3:0] r_done, w_done_nxt;
   logic       r_en, w_en_nxt;
   logic       w_found;
   logic [1:0] w_win;
   logic       w_hold_ok, w_gap_ok;

`ifdef CDC_XFER_ACK_EN
   logic r_ack_s1, r_ack_s2;

   // two-flop synchronizer bringing the destination ack into clk_a
   always_ff @(posedge clk_a) begin
      if (arst) begin
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_ack_s1 <= ack_b;
         r_ack_s2 <= r_ack_s1;
      end
   end

   assign w_hold_ok = r_ack_s2;
   assign w_gap_ok  = ~r_ack_s2;
`else
   assign w_hold_ok = 1'b1;
   assign w_gap_ok  = 1'b1;
`endif

   // round-robin search starting one past the last winner
   always_comb begin
      w_found = 1'b0;
      w_win   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         if (!w_found && req[2'(r_last + 2'(k))]) begin
            w_found = 1'b1;
            w_win   = 2'(r_last + 2'(k));
         end
      end
   end

   // next-state and registered-output computation; counters saturate at 0
   // so the ack-gated build can wait past the minimum hold/gap time
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_data_nxt  = r_data;
      w_gnt_nxt   = r_gnt;
      w_en_nxt    = r_en;
      w_done_nxt  = 4'd0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = HOLD;
               w_data_nxt  = req_data[{w_win, 2'b00} +: 4];
               w_en_nxt    = 1'b1;
               w_gnt_nxt   = 4'b0001 << w_win;
               w_last_nxt  = w_win;
               w_cnt_nxt   = 8'(HOLD_CYC - 1);
            end
         end
         HOLD: begin
            if (r_cnt == 8'd0 && w_hold_ok) begin
               w_state_nxt = GAP;
               w_en_nxt    = 1'b0;
               w_done_nxt  = r_gnt;
               w_cnt_nxt   = 8'(GAP_CYC - 1);
            end else if (r_cnt != 8'd0) begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         GAP: begin
            if (r_cnt == 8'd0 && w_gap_ok) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = 4'd0;
            end else if (r_cnt != 8'd0) begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'd0;
            w_en_nxt    = 1'b0;
         end
      endcase
   end

   // state and output registers; reset aborts any transfer without done
   always_ff @(posedge clk_a) begin
      if (arst) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_last  <= 2'd3;
         r_data  <= 4'd0;
         r_gnt   <= 4'd0;
         r_done  <= 4'd0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_data  <= w_data_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
         r_en    <= w_en_nxt;
      end
   end

   assign xfer_data = r_data;
   assign xfer_en   = r_en;
   assign gnt       = r_gnt;
   assign done      = r_done;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter (default build, HOLD_CYC=6, GAP_CYC=2).
// Expected grants {gnt,data} are queued when requests are driven and
// popped by a monitor on each xfer_en rising edge.
module tb_cdc_xfer_arbiter;
   localparam int HOLD = 6;
   localparam int GAP  = 2;

   logic        clk_a = 1'b0;
   logic        arst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  xfer_data;
   logic        xfer_en;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
`ifdef CDC_XFER_ACK_EN
   logic        ack_b = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;
   int cyc   = 0;
   logic [7:0] sb_q[$];
   logic [3:0] cur_gnt = 4'd0;
   bit spacing_on = 1'b0;
   int last_rise  = -1;

   cdc_xfer_arbiter #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
      .clk_a(clk_a),
      .arst(arst),
`ifdef CDC_XFER_ACK_EN
      .ack_b(ack_b),
`endif
      .req(req),
      .req_data(req_data),
      .xfer_data(xfer_data),
      .xfer_en(xfer_en),
      .gnt(gnt),
      .done(done),
      .busy(busy)
   );

   always #5 clk_a = ~clk_a;
   always @(posedge clk_a) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_a);
      #1;
   endtask

   // hold req until done pulses, then drop it and wait for idle
   task automatic finish_xfer(input int maxc);
      int i;
      bit ok;
      ok = 1'b0;
      for (i = 0; i < maxc; i++) begin
         if (done != 4'd0) req = 4'd0;
         if (req == 4'd0 && !busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("finish_timeout", {31'd0, ok}, 32'd1);
   endtask

   // monitor: scoreboard pop on xfer_en rise, hold length, done owner, spacing
   initial begin
      bit prev_en;
      int en_len;
      logic [7:0] e;
      prev_en = 1'b0;
      en_len  = 0;
      forever begin
         @(negedge clk_a);
         if (arst) begin
            prev_en = 1'b0;
            en_len  = 0;
         end else begin
            if (xfer_en) en_len++;
            if (xfer_en && !prev_en) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_xfer", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  n_pop++;
                  cur_gnt = e[7:4];
                  chk("sb_gnt", {28'd0, gnt}, {28'd0, e[7:4]});
                  chk("sb_data", {28'd0, xfer_data}, {28'd0, e[3:0]});
               end
               if (spacing_on && last_rise >= 0)
                  chk("rise_spacing", cyc - last_rise, HOLD + GAP + 1);
               last_rise = cyc;
            end
            if (prev_en && !xfer_en) begin
               chk("hold_len", en_len, HOLD);
               en_len = 0;
            end
            if (done != 4'd0) chk("done_owner", {28'd0, done}, {28'd0, cur_gnt});
            prev_en = xfer_en;
         end
      end
   end

   initial begin
      arst     = 1'b1;
      req      = 4'hF;
      req_data = 16'h0;

      // reset held with all requests high: nothing may come out
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_en", {31'd0, xfer_en}, 32'd0);
         chk("rst_gnt", {28'd0, gnt}, 32'd0);
         chk("rst_done", {28'd0, done}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_data", {28'd0, xfer_data}, 32'd0);
      end
      req  = 4'd0;
      arst = 1'b0;
      tick();

      // single transfer, directed cycle timing
      req      = 4'b0100;
      req_data = 16'h0A00;
      sb_q.push_back({4'b0100, 4'hA});
      for (int c = 1; c <= HOLD; c++) begin
         tick();
         chk("a_en", {31'd0, xfer_en}, 32'd1);
         chk("a_data", {28'd0, xfer_data}, 32'hA);
         chk("a_busy", {31'd0, busy}, 32'd1);
         chk("a_done_lo", {28'd0, done}, 32'd0);
      end
      tick(); // cycle 7
      chk("a_done", {28'd0, done}, 32'b0100);
      chk("a_en_off", {31'd0, xfer_en}, 32'd0);
      req = 4'd0;
      tick(); // cycle 8
      chk("a_done_1cyc", {28'd0, done}, 32'd0);
      chk("a_gnt_gap", {28'd0, gnt}, 32'b0100);
      chk("a_data_gap", {28'd0, xfer_data}, 32'hA);
      chk("a_busy_gap", {31'd0, busy}, 32'd1);
      tick(); // cycle 9
      chk("a_gnt_idle", {28'd0, gnt}, 32'd0);
      chk("a_busy_idle", {31'd0, busy}, 32'd0);
      chk("a_data_keep", {28'd0, xfer_data}, 32'hA);

      // rotation with all requests held, starting fresh from reset
      arst = 1'b1;
      tick();
      arst       = 1'b0;
      spacing_on = 1'b1;
      last_rise  = -1;
      req_data   = 16'h4321;
      req        = 4'hF;
      sb_q.push_back({4'b0001, 4'h1});
      sb_q.push_back({4'b0010, 4'h2});
      sb_q.push_back({4'b0100, 4'h3});
      sb_q.push_back({4'b1000, 4'h4});
      sb_q.push_back({4'b0001, 4'h1});
      begin
         int target;
         bit ok;
         target = n_pop + 5;
         ok = 1'b0;
         for (int i = 0; i < 80; i++) begin
            tick();
            if (n_pop >= target) begin
               ok = 1'b1;
               break;
            end
         end
         chk("rot_timeout", {31'd0, ok}, 32'd1);
      end
      req = 4'd0;
      finish_xfer(40);
      spacing_on = 1'b0;

      // requester drops mid-hold: transfer still runs to completion
      req      = 4'b0010;
      req_data = 16'h0050;
      sb_q.push_back({4'b0010, 4'h5});
      tick(); tick(); tick(); // cycle 3 of hold
      req = 4'd0;
      for (int c = 4; c <= HOLD; c++) begin
         tick();
         chk("c_en_held", {31'd0, xfer_en}, 32'd1);
      end
      tick();
      chk("c_done", {28'd0, done}, 32'b0010);
      for (int i = 0; i < 6; i++) tick();
      chk("c_no_regrant_en", {31'd0, xfer_en}, 32'd0);
      chk("c_no_regrant_busy", {31'd0, busy}, 32'd0);

      // reset in the middle of hold aborts with no done pulse
      req      = 4'b1000;
      req_data = 16'h7000;
      sb_q.push_back({4'b1000, 4'h7});
      for (int c = 1; c <= 4; c++) tick();
      chk("d_en_pre", {31'd0, xfer_en}, 32'd1);
      arst = 1'b1;
      tick();
      chk("d_en_rst", {31'd0, xfer_en}, 32'd0);
      chk("d_gnt_rst", {28'd0, gnt}, 32'd0);
      chk("d_done_rst", {28'd0, done}, 32'd0);
      chk("d_busy_rst", {31'd0, busy}, 32'd0);
      arst     = 1'b0;
      req      = 4'b0001;
      req_data = 16'h0009;
      sb_q.push_back({4'b0001, 4'h9});
      tick();
      chk("d_done_after", {28'd0, done}, 32'd0);
      chk("d_gnt_after", {28'd0, gnt}, 32'b0001);
      finish_xfer(40);

      tick();
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
